// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and constants for the SDRAM responder model.
// Provides the command enum, the per-bank state enum, the mode-register struct,
// the BL/CL decode constants, and helpers that decode strobes and mode words.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_DESEL,
        CMD_NOP,
        CMD_ACTIVE,
        CMD_READ,
        CMD_WRITE,
        CMD_PRECHARGE,
        CMD_REFRESH,
        CMD_LOAD_MODE
    } cmd_t;

    typedef enum logic {
        BANK_IDLE = 1'b0,
        BANK_OPEN = 1'b1
    } bank_state_t;

    // bl holds the burst length as a count (1, 2 or 4); cl holds the CAS latency (2 or 3)
    typedef struct packed {
        logic [2:0] bl;
        logic [1:0] cl;
    } mode_t;

    localparam logic [2:0] BL_1 = 3'd1;
    localparam logic [2:0] BL_2 = 3'd2;
    localparam logic [2:0] BL_4 = 3'd4;
    localparam logic [1:0] CL_2 = 2'd2;
    localparam logic [1:0] CL_3 = 2'd3;
    localparam mode_t MODE_RESET = '{bl: BL_1, cl: CL_2};

    function automatic cmd_t decode_cmd(input logic cs, input logic ras,
                                        input logic cas, input logic we);
        cmd_t c;
        if (cs) begin
            c = CMD_DESEL;
        end else begin
            case ({ras, cas, we})
                3'b111:  c = CMD_NOP;
                3'b011:  c = CMD_ACTIVE;
                3'b101:  c = CMD_READ;
                3'b100:  c = CMD_WRITE;
                3'b010:  c = CMD_PRECHARGE;
                3'b001:  c = CMD_REFRESH;
                3'b000:  c = CMD_LOAD_MODE;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

    // Mode word bits [1:0] select BL, bit [2] selects CL. The reserved BL code 3 maps to BL=1.
    function automatic mode_t decode_mode(input logic [2:0] code);
        mode_t m;
        case (code[1:0])
            2'd1:    m.bl = BL_2;
            2'd2:    m.bl = BL_4;
            default: m.bl = BL_1;
        endcase
        m.cl = code[2] ? CL_3 : CL_2;
        return m;
    endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// sdram_resp_bank: state (IDLE/OPEN) and open-row register for one SDRAM bank.
// Ports: clk/rst (sync, active-high), en (clock enable), act/pre (already-qualified
// ACTIVE/PRECHARGE for this bank), row_in (row to latch); state and row outputs.
module sdram_resp_bank
    import sdram_pkg::*;
#(
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             act,
    input  logic             pre,
    input  logic [ROW_W-1:0] row_in,
    output bank_state_t      state,
    output logic [ROW_W-1:0] row
);

    bank_state_t state_q, state_nxt;
    logic [ROW_W-1:0] row_q, row_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BANK_IDLE;
            row_q   <= '0;
        end else if (en) begin
            state_q <= state_nxt;
            row_q   <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        row_nxt   = row_q;
        case (state_q)
            BANK_IDLE: if (act) begin
                state_nxt = BANK_OPEN;
                row_nxt   = row_in;
            end
            BANK_OPEN: if (pre) state_nxt = BANK_IDLE;
            default:   state_nxt = BANK_IDLE;
        endcase
    end

    assign state = state_q;
    assign row   = row_q;

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: behavioural SDRAM device model answering a controller's commands.
// Ports: CLK/RST (sync, active-high), CKE freeze, CS/RAS/CAS/WE_IN strobes, BA, ADR_IN, DIN in;
// DOUT/DOUT_VLD read beats CL cycles after each read cycle; ERR protocol-violation pulse.
// Optional checker enabled by macro SDRAM_RESP_CHECK_EN (ERR tied low otherwise).
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int BANK_W = 2
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic                                       CKE,
    input  logic                                       CS,
    input  logic                                       RAS,
    input  logic                                       CAS,
    input  logic                                       WE_IN,
    input  logic [BANK_W-1:0]                          BA,
    input  logic [((ROW_W > COL_W) ? ROW_W : COL_W)-1:0] ADR_IN,
    input  logic [DATA_W-1:0]                          DIN,
    output logic [DATA_W-1:0]                          DOUT,
    output logic                                       DOUT_VLD,
    output logic                                       ERR
);

    localparam int NB    = 2 ** BANK_W;
    localparam int AW    = BANK_W + ROW_W + COL_W;
    localparam int DEPTH = 2 ** AW;

    cmd_t  cmd;
    mode_t mode;

    bank_state_t      bank_state [NB];
    logic [ROW_W-1:0] bank_row   [NB];
    logic [NB-1:0]    bank_open;
    logic             cur_open;
    logic             all_idle;

    logic acc_act, acc_pre, acc_rd, acc_wr, acc_lmr, pre_hit;

    // burst engine: beats after the first one of a READ/WRITE
    logic              bst_act, bst_act_nxt;
    logic              bst_rd, bst_rd_nxt;
    logic [BANK_W-1:0] bst_bank, bst_bank_nxt;
    logic [ROW_W-1:0]  bst_row, bst_row_nxt;
    logic [COL_W-1:0]  bst_col, bst_col_nxt;
    logic [2:0]        bst_off, bst_off_nxt;
    logic [2:0]        bst_left, bst_left_nxt;
    logic [COL_W-1:0]  bl_mask, wrap_col;

    logic              beat_rd, beat_wr;
    logic [BANK_W-1:0] beat_bank;
    logic [ROW_W-1:0]  beat_row;
    logic [COL_W-1:0]  beat_col;
    logic [AW-1:0]     beat_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [2:0]        pipe_vld;
    logic [DATA_W-1:0] pipe_dat [3];
    logic [DATA_W-1:0] dout_q;
    logic              dout_vld_q;

    assign cmd = decode_cmd(CS, RAS, CAS, WE_IN);

    for (genvar b = 0; b < NB; b++) begin : g_bank
        sdram_resp_bank #(.ROW_W(ROW_W)) u_bank (
            .clk    (CLK),
            .rst    (RST),
            .en     (CKE),
            .act    (acc_act && (BA == BANK_W'(b))),
            .pre    (acc_pre && (BA == BANK_W'(b))),
            .row_in (ADR_IN[ROW_W-1:0]),
            .state  (bank_state[b]),
            .row    (bank_row[b])
        );
        assign bank_open[b] = (bank_state[b] == BANK_OPEN);
    end

    assign cur_open = bank_open[BA];
    assign all_idle = ~|bank_open;

    // PRECHARGE aimed at the bank that is mid-burst only cuts the burst; the bank stays open
    assign pre_hit = (cmd == CMD_PRECHARGE) && bst_act && (bst_bank == BA);
    assign acc_act = (cmd == CMD_ACTIVE) && !cur_open;
    assign acc_pre = (cmd == CMD_PRECHARGE) && cur_open && !pre_hit;
    assign acc_rd  = (cmd == CMD_READ) && cur_open;
    assign acc_wr  = (cmd == CMD_WRITE) && cur_open;
    assign acc_lmr = (cmd == CMD_LOAD_MODE) && all_idle;

    // column wraps inside the BL-aligned block: upper bits from start, low bits count
    assign bl_mask  = COL_W'(mode.bl) - COL_W'(1);
    assign wrap_col = (bst_col & ~bl_mask) | ((bst_col + COL_W'(bst_off)) & bl_mask);

    always_comb begin
        beat_rd      = 1'b0;
        beat_wr      = 1'b0;
        beat_bank    = BA;
        beat_row     = bank_row[BA];
        beat_col     = ADR_IN[COL_W-1:0];
        bst_act_nxt  = bst_act;
        bst_rd_nxt   = bst_rd;
        bst_bank_nxt = bst_bank;
        bst_row_nxt  = bst_row;
        bst_col_nxt  = bst_col;
        bst_off_nxt  = bst_off;
        bst_left_nxt = bst_left;
        if (acc_rd || acc_wr) begin
            // first beat happens in the command cycle; a running burst is dropped
            beat_rd      = acc_rd;
            beat_wr      = acc_wr;
            bst_act_nxt  = (mode.bl != BL_1);
            bst_rd_nxt   = acc_rd;
            bst_bank_nxt = BA;
            bst_row_nxt  = bank_row[BA];
            bst_col_nxt  = ADR_IN[COL_W-1:0];
            bst_off_nxt  = 3'd1;
            bst_left_nxt = mode.bl - 3'd1;
        end else if (bst_act) begin
            if (pre_hit) begin
                bst_act_nxt = 1'b0;
            end else begin
                beat_rd      = bst_rd;
                beat_wr      = !bst_rd;
                beat_bank    = bst_bank;
                beat_row     = bst_row;
                beat_col     = wrap_col;
                bst_off_nxt  = bst_off + 3'd1;
                bst_left_nxt = bst_left - 3'd1;
                bst_act_nxt  = (bst_left > 3'd1);
            end
        end
    end

    assign beat_addr = {beat_bank, beat_row, beat_col};

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode     <= MODE_RESET;
            bst_act  <= 1'b0;
            bst_rd   <= 1'b0;
            bst_bank <= '0;
            bst_row  <= '0;
            bst_col  <= '0;
            bst_off  <= '0;
            bst_left <= '0;
        end else if (CKE) begin
            if (acc_lmr) mode <= decode_mode(ADR_IN[2:0]);
            bst_act  <= bst_act_nxt;
            bst_rd   <= bst_rd_nxt;
            bst_bank <= bst_bank_nxt;
            bst_row  <= bst_row_nxt;
            bst_col  <= bst_col_nxt;
            bst_off  <= bst_off_nxt;
            bst_left <= bst_left_nxt;
        end
    end

    // array contents survive reset
    always_ff @(posedge CLK) begin
        if (CKE && !RST && beat_wr) mem[beat_addr] <= DIN;
    end

    // pipe stage i holds a beat read i edges ago; invalid stages carry zero data
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_vld    <= '0;
            pipe_dat[0] <= '0;
            pipe_dat[1] <= '0;
            pipe_dat[2] <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
        end else if (CKE) begin
            pipe_vld    <= {pipe_vld[1:0], beat_rd};
            pipe_dat[0] <= beat_rd ? mem[beat_addr] : '0;
            pipe_dat[1] <= pipe_dat[0];
            pipe_dat[2] <= pipe_dat[1];
            if (mode.cl == CL_3) begin
                dout_q     <= pipe_dat[2];
                dout_vld_q <= pipe_vld[2];
            end else begin
                dout_q     <= pipe_dat[1];
                dout_vld_q <= pipe_vld[1];
            end
        end
    end

    assign DOUT     = dout_q;
    assign DOUT_VLD = dout_vld_q;

`ifdef SDRAM_RESP_CHECK_EN
    logic illegal;
    logic err_q;

    assign illegal = ((cmd == CMD_ACTIVE)    &&  cur_open)
                   | ((cmd == CMD_READ)      && !cur_open)
                   | ((cmd == CMD_WRITE)     && !cur_open)
                   | ((cmd == CMD_PRECHARGE) && (!cur_open || pre_hit))
                   | ((cmd == CMD_REFRESH)   && !all_idle)
                   | ((cmd == CMD_LOAD_MODE) && !all_idle);

    always_ff @(posedge CLK) begin
        if (RST)      err_q <= 1'b0;
        else if (CKE) err_q <= illegal;
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed bench for sdram_responder.
// Inputs change 1 time unit after each rising edge and outputs are sampled there too,
// so each tick() observes the state produced by exactly one clock edge.
module tb_sdram_responder;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        rst, cke, cs, ras, cas, we;
    logic [1:0]  ba;
    logic [3:0]  adr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_vld, err;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_seq [4];

    always #5 clk = ~clk;

    sdram_responder #(.DATA_W(16), .ROW_W(4), .COL_W(4), .BANK_W(2)) dut (
        .CLK      (clk),
        .RST      (rst),
        .CKE      (cke),
        .CS       (cs),
        .RAS      (ras),
        .CAS      (cas),
        .WE_IN    (we),
        .BA       (ba),
        .ADR_IN   (adr),
        .DIN      (din),
        .DOUT     (dout),
        .DOUT_VLD (dout_vld),
        .ERR      (err)
    );

    task automatic put(input logic [3:0] c, input logic [1:0] b,
                       input logic [3:0] a, input logic [15:0] d);
        {cs, ras, cas, we} = c;
        ba  = b;
        adr = a;
        din = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        cke = 1'b1;
        put(C_NOP, 2'd0, 4'd0, 16'h0);
        tick();
        tick();
        chk("rst_vld", {31'd0, dout_vld}, 32'd0);
        chk("rst_dout", {16'd0, dout}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // BL=1, CL=2 single write/read
        put(C_LMR, 2'd0, 4'd0, 16'h0);       tick();
        put(C_ACT, 2'd0, 4'd3, 16'h0);       tick();
        put(C_WR,  2'd0, 4'd5, 16'hA5A5);    tick();
        put(C_RD,  2'd0, 4'd5, 16'h0);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'h0);
        chk("bl1_edge0_vld", {31'd0, dout_vld}, 32'd0);
        tick();
        chk("bl1_edge1_vld", {31'd0, dout_vld}, 32'd0);
        tick();
        chk("bl1_edge2_vld", {31'd0, dout_vld}, 32'd1);
        chk("bl1_edge2_dout", {16'd0, dout}, 32'h0000A5A5);
        tick();
        chk("bl1_after_vld", {31'd0, dout_vld}, 32'd0);
        chk("bl1_after_dout", {16'd0, dout}, 32'd0);

        // BL=4, CL=3 burst write and wrapped reads on bank 1
        put(C_PRE, 2'd0, 4'd0, 16'h0);       tick();
        put(C_LMR, 2'd0, 4'd6, 16'h0);       tick();
        put(C_ACT, 2'd1, 4'd2, 16'h0);       tick();
        put(C_WR,  2'd1, 4'd6, 16'd1);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'd2);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'd3);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'd4);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'd0);       tick();

        put(C_RD,  2'd1, 4'd6, 16'h0);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'h0);
        tick();
        chk("bl4_c6_edge1_vld", {31'd0, dout_vld}, 32'd0);
        tick();
        chk("bl4_c6_edge2_vld", {31'd0, dout_vld}, 32'd0);
        exp_seq[0] = 16'd1; exp_seq[1] = 16'd2; exp_seq[2] = 16'd3; exp_seq[3] = 16'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bl4_c6_beat%0d_vld", i), {31'd0, dout_vld}, 32'd1);
            chk($sformatf("bl4_c6_beat%0d_dout", i), {16'd0, dout}, {16'd0, exp_seq[i]});
        end
        tick();
        chk("bl4_c6_end_vld", {31'd0, dout_vld}, 32'd0);

        // start at col 4: visits 4,5,6,7 which hold 3,4,1,2
        put(C_RD,  2'd1, 4'd4, 16'h0);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'h0);
        tick();
        tick();
        exp_seq[0] = 16'd3; exp_seq[1] = 16'd4; exp_seq[2] = 16'd1; exp_seq[3] = 16'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bl4_c4_beat%0d", i), {15'd0, dout_vld, dout}, {16'h1, exp_seq[i]});
        end
        tick();
        chk("bl4_c4_end_vld", {31'd0, dout_vld}, 32'd0);

        // READ to idle bank 2
        put(C_RD,  2'd2, 4'd0, 16'h0);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'h0);
`ifdef SDRAM_RESP_CHECK_EN
        chk("idle_rd_err_pulse", {31'd0, err}, 32'd1);
`else
        chk("idle_rd_err_tied", {31'd0, err}, 32'd0);
`endif
        tick();
        chk("idle_rd_err_clear", {31'd0, err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("idle_rd_vld%0d", i), {31'd0, dout_vld}, 32'd0);
            tick();
        end

        // CKE low for two edges after the first beat emerges
        put(C_RD,  2'd1, 4'd6, 16'h0);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'h0);
        tick();
        tick();
        tick();
        chk("cke_beat0", {15'd0, dout_vld, dout}, 32'h0001_0001);
        cke = 1'b0;
        tick();
        chk("cke_hold0", {15'd0, dout_vld, dout}, 32'h0001_0001);
        tick();
        chk("cke_hold1", {15'd0, dout_vld, dout}, 32'h0001_0001);
        cke = 1'b1;
        exp_seq[0] = 16'd2; exp_seq[1] = 16'd3; exp_seq[2] = 16'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("cke_beat%0d", i + 1), {15'd0, dout_vld, dout}, {16'h1, exp_seq[i]});
        end
        tick();
        chk("cke_end_vld", {31'd0, dout_vld}, 32'd0);

        // reset in the middle of a burst
        put(C_RD,  2'd1, 4'd6, 16'h0);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'h0);
        tick();
        tick();
        tick();
        chk("rstmid_beat0", {15'd0, dout_vld, dout}, 32'h0001_0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_vld", {31'd0, dout_vld}, 32'd0);
        chk("rstmid_dout", {16'd0, dout}, 32'd0);

        put(C_RD,  2'd1, 4'd6, 16'h0);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'h0);
`ifdef SDRAM_RESP_CHECK_EN
        chk("rstmid_rd_err", {31'd0, err}, 32'd1);
`else
        chk("rstmid_rd_err_tied", {31'd0, err}, 32'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rstmid_ignored_vld%0d", i), {31'd0, dout_vld}, 32'd0);
        end

        // after ACTIVE reissue: default BL=1/CL=2 and array contents retained
        put(C_ACT, 2'd1, 4'd2, 16'h0);       tick();
        put(C_RD,  2'd1, 4'd6, 16'h0);       tick();
        put(C_NOP, 2'd0, 4'd0, 16'h0);
        tick();
        chk("reopen_edge1_vld", {31'd0, dout_vld}, 32'd0);
        tick();
        chk("reopen_beat", {15'd0, dout_vld, dout}, 32'h0001_0001);
        tick();
        chk("reopen_end_vld", {31'd0, dout_vld}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
